alu_pipe: RTL
=============

Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined successor to the single-cycle combinational ALU.
- Accepts one operation per cycle through a valid/ready handshake and returns the result and flags two cycles later.
- Supports full backpressure, a sticky overflow status, an illegal-op flag and a completed-operation counter.
- Sits between the decode/issue logic and writeback in the datapath.

Parameters:
- WIDTH, 32, operand and result width in bits (must be ≥ 2).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation presented on x/y/op.
- in_ready  output  1  block can accept the operation this cycle.
- x  input  WIDTH  operand A.
- y  input  WIDTH  operand B; also the shift amount source.
- op  input  3  operation code.
- out_valid  output  1  result is present on z and the flags.
- out_ready  input  1  consumer accepts the result this cycle.
- z  output  WIDTH  result.
- equal  output  1  x == y for the operation.
- overflow  output  1  signed overflow of ADD/SUB.
- zero  output  1  z == 0.
- illegal  output  1  op was the reserved encoding.
- sticky_ovf  output  1  overflow seen since reset or last clear.
- clr_sticky  input  1  clears sticky_ovf.
- ops_done  output  CNT_W  count of completed output transfers.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset state, next edge with rst=1:
  - both stage valid bits = 0, so out_valid=0;
  - z = 0; equal, overflow, zero, illegal = 0;
  - sticky_ovf = 0; ops_done = 0.
- Reset mid-operation: in-flight operations are discarded and never produce a transfer.
- Opcode encodings:
  - 000 AND, 001 ADD, 010 SUB, 011 SLT, 100 SRL, 101 SLL, 110 SRA.
  - 111 is reserved.
- Transfers:
  - Input transfer = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
- Stage 1 (S1) registers x, y and op on an input transfer.
- Stage 2 (S2) registers z and all flags computed from S1.
- Advance rules:
  - S2 loads when S1 is valid and (S2 is empty or out_ready=1).
  - in_ready = !s1_valid || s2 loads this cycle. The ready path is combinational through out_ready.
- Throughput and latency:
  - Full throughput: one operation per cycle when out_ready is held high.
  - Latency: an input accepted at edge N is presented with out_valid=1 after edge N+1.
- Stalls:
  - While out_valid=1 and out_ready=0, z and all flags hold stable.
  - No operation is dropped or duplicated under any valid/ready pattern.
- Arithmetic, all WIDTH-bit with wrap-around:
  - ADD: z = x + y.
  - SUB: z = x − y.
  - ADD overflow = operand signs equal and result sign differs.
  - SUB overflow = operand signs differ and result sign differs from x.
  - All other ops: overflow = 0.
- SLT: z = 1 (zero-extended) if signed x < signed y, else 0. The comparison is exact even when x − y overflows; overflow = 0.
- Shifts:
  - Shift amount = y[$clog2(WIDTH)-1:0]; upper bits of y are ignored.
  - SRL and SLL fill with zeros; SRA replicates x[WIDTH-1].
- Reserved op 111: z = 0, zero = 1, illegal = 1, overflow = 0.
- Flags:
  - equal reflects x == y for every op.
  - zero reflects the registered z.
- sticky_ovf:
  - Set on an output transfer carrying overflow=1.
  - Cleared by clr_sticky=1.
  - Set and clear in the same cycle: set wins.
- ops_done: increments on each output transfer and wraps from 2^CNT_W−1 to 0.

Test Plan:
- Reset, then ADD x=0x7FFFFFFF, y=0x00000001 with out_ready=1 → after 2 edges: z=0x80000000, overflow=1, zero=0, equal=0; sticky_ovf=1 one edge after the transfer; ops_done=1.
- Back-to-back SUB x=y=0x80000000, then AND x=0x55555555, y=0xAAAAAAAA, then SLT x=0x80000000, y=0x00000001 → three consecutive out_valid cycles:
  - SUB: z=0, zero=1, equal=1, overflow=0.
  - AND: z=0, zero=1, equal=0.
  - SLT: z=1.
- Backpressure: issue 4 ops with out_ready=0 → in_ready drops after 2 accepted ops and first result held stable; then release out_ready → all 4 results delivered in order, ops_done=4.
- Shifts with x=0x80000010, y=0x00000024 (amount 4) → SRL 0x08000001, SLL 0x00000100, SRA 0xF8000001.
- op=111, x=y=0xFFFFFFFF → z=0, zero=1, illegal=1, equal=1.
- Assert rst while 2 ops are in flight → out_valid=0 after the edge, neither op emerges; sticky_ovf=0, ops_done=0. Separately, drive clr_sticky=1 on the same cycle as an overflowing transfer → sticky_ovf=1.

Source files
------------

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with a valid/ready handshake on both sides.
// S1 captures operands; S2 holds the registered result, flags and status.
module alu_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             equal,
  output logic             overflow,
  output logic             zero,
  output logic             illegal,
  output logic             sticky_ovf,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] ops_done
);

  localparam int unsigned SH_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned MSB  = WIDTH - 1;

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_x_q;
  logic [WIDTH-1:0] s1_y_q;
  logic [2:0]       s1_op_q;

  logic             s2_valid_q;
  logic [WIDTH-1:0] z_q;
  logic             equal_q;
  logic             overflow_q;
  logic             zero_q;
  logic             illegal_q;
  logic             sticky_q;
  logic [CNT_W-1:0] cnt_q;

  logic             s2_load;
  logic             in_xfer;
  logic             out_xfer;
  logic [WIDTH-1:0] add_r;
  logic [WIDTH-1:0] sub_r;
  logic [SH_W-1:0]  sh_amt;
  logic             slt_r;
  logic [WIDTH-1:0] z_d;
  logic             overflow_d;
  logic             illegal_d;
  logic             equal_d;
  logic             zero_d;

  // S2 drains when the consumer takes its result, letting S1 move up in the same cycle.
  assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_load;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = s2_valid_q && out_ready;

  assign add_r  = s1_x_q + s1_y_q;
  assign sub_r  = s1_x_q - s1_y_q;
  assign sh_amt = s1_y_q[SH_W-1:0];
  assign slt_r  = $signed(s1_x_q) < $signed(s1_y_q);

  // Result and flags computed from the S1 operands.
  always_comb begin
    z_d        = '0;
    overflow_d = 1'b0;
    illegal_d  = 1'b0;
    case (s1_op_q)
      3'b000: z_d = s1_x_q & s1_y_q;
      3'b001: begin
        z_d        = add_r;
        overflow_d = (s1_x_q[MSB] == s1_y_q[MSB]) && (add_r[MSB] != s1_x_q[MSB]);
      end
      3'b010: begin
        z_d        = sub_r;
        overflow_d = (s1_x_q[MSB] != s1_y_q[MSB]) && (sub_r[MSB] != s1_x_q[MSB]);
      end
      3'b011: z_d = WIDTH'(slt_r);
      3'b100: z_d = s1_x_q >> sh_amt;
      3'b101: z_d = s1_x_q << sh_amt;
      3'b110: z_d = WIDTH'($signed(s1_x_q) >>> sh_amt);
      default: illegal_d = 1'b1;
    endcase
    equal_d = (s1_x_q == s1_y_q);
    zero_d  = (z_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_op_q    <= '0;
      s2_valid_q <= 1'b0;
      z_q        <= '0;
      equal_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      illegal_q  <= 1'b0;
      sticky_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (in_xfer) begin
        s1_valid_q <= 1'b1;
        s1_x_q     <= x;
        s1_y_q     <= y;
        s1_op_q    <= op;
      end else if (s2_load) begin
        s1_valid_q <= 1'b0;
      end

      if (s2_load) begin
        s2_valid_q <= 1'b1;
        z_q        <= z_d;
        equal_q    <= equal_d;
        overflow_q <= overflow_d;
        zero_q     <= zero_d;
        illegal_q  <= illegal_d;
      end else if (out_ready) begin
        s2_valid_q <= 1'b0;
      end

      // A set from an overflowing transfer takes priority over a clear.
      if (out_xfer && overflow_q) begin
        sticky_q <= 1'b1;
      end else if (clr_sticky) begin
        sticky_q <= 1'b0;
      end

      if (out_xfer) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign z          = z_q;
  assign equal      = equal_q;
  assign overflow   = overflow_q;
  assign zero       = zero_q;
  assign illegal    = illegal_q;
  assign sticky_ovf = sticky_q;
  assign ops_done   = cnt_q;

endmodule
